// File: rtl/rst_seq_pkg.sv
// Shared types and default sizes for the multi-channel reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } rst_seq_state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable down-counter shared by all channels; saturates at zero instead of wrapping.
module rst_seq_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: load has priority, decrement only while non-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Releases NUM_CH reset outputs one after another, each after its own programmed delay.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    parameter  int CNT_W  = DEF_CNT_W,
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [NUM_CH*CNT_W-1:0] dly_i,
    output logic [NUM_CH-1:0]       ch_rst_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [IDX_W-1:0]        ch_idx_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    rst_seq_state_e     state_d, state_q;
    logic [NUM_CH-1:0]  ch_rst_d, ch_rst_q;
    logic               busy_d, busy_q;
    logic               done_d, done_q;
    logic [IDX_W-1:0]   idx_d, idx_q;
    logic [IDX_W-1:0]   nxt_idx;
    logic [CNT_W-1:0]   dly_d [NUM_CH];
    logic [CNT_W-1:0]   dly_q [NUM_CH];

    logic               cnt_load;
    logic               cnt_en;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_zero;

    assign nxt_idx = idx_q + IDX_W'(1);

    rst_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .val_i  (cnt_val),
        .zero_o (cnt_zero)
    );

    // Sequencer next-state and output decisions; abort overrides everything outside IDLE.
    always_comb begin
        state_d  = state_q;
        ch_rst_d = ch_rst_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        idx_d    = idx_q;
        dly_d    = dly_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = '0;

        case (state_q)
            IDLE: begin
                if (abort_i) begin
                    ch_rst_d = '1;
                end else if (start_i) begin
                    ch_rst_d = '1;
                    busy_d   = 1'b1;
                    idx_d    = '0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (!abort_i) begin
                    for (int j = 0; j < NUM_CH; j++) begin
                        dly_d[j] = dly_i[j*CNT_W +: CNT_W];
                    end
                    cnt_load = 1'b1;
                    cnt_val  = dly_i[CNT_W-1:0];
                    state_d  = COUNT;
                end
            end
            COUNT: begin
                if (!abort_i) begin
                    if (!cnt_zero) begin
                        cnt_en = 1'b1;
                    end else begin
                        ch_rst_d[idx_q] = 1'b0;
                        if (idx_q == LAST_IDX) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            idx_d    = nxt_idx;
                            cnt_load = 1'b1;
                            cnt_val  = dly_q[nxt_idx];
                        end
                    end
                end
            end
            DONE: begin
                if (!abort_i) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort_i && (state_q != IDLE)) begin
            ch_rst_d = '1;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            idx_d    = '0;
            state_d  = IDLE;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_rst_q <= '1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            ch_rst_q <= ch_rst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            idx_q    <= idx_d;
        end
    end

    // Delay snapshot; only meaningful after LOAD, so it carries no reset.
    always_ff @(posedge clk) begin
        dly_q <= dly_d;
    end

    assign ch_rst_o = ch_rst_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign ch_idx_o = idx_q;

endmodule
